stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50_000_000, giving CLK cycles per one-second tick; legal range 2..2^26.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port KEY_SS  input  1  start/stop button, asynchronous, active-high level.
REQ-005 The block SHALL have port KEY_CLR  input  1  clear button, asynchronous, active-high level.
REQ-006 The block SHALL have port KEY_LAP  input  1  lap button, asynchronous, active-high level.
REQ-007 The block SHALL have port SEC_ONES  output  4  displayed seconds units digit, BCD 0..9.
REQ-008 The block SHALL have port SEC_TENS  output  4  displayed seconds tens digit, BCD 0..5.
REQ-009 The block SHALL have port RUNNING  output  1  high while in state RUN.
REQ-010 The block SHALL have port LAP_ACTIVE  output  1  high while the display is frozen on a lap snapshot.
REQ-011 The block SHALL have port TICK  output  1  one-cycle pulse on each counted second.

Function
REQ-012 Each KEY input SHALL pass a 2-flop synchronizer, then rising-edge detect; one press event per 0->1 transition of the synchronized level, no repeat while held.
REQ-013 A press event SHALL take effect on the 3rd rising CLK edge after the KEY input rises (input setup met); outputs reflect it on the 4th.
REQ-014 States SHALL be IDLE, RUN, PAUSE, encoded in one registered state variable.
REQ-015 Transitions: IDLE+SS -> RUN; RUN+SS -> PAUSE; PAUSE+SS -> RUN; PAUSE+CLR -> IDLE; IDLE+CLR -> IDLE; RUN+CLR ignored.
REQ-016 Simultaneous SS and CLR events in PAUSE or IDLE SHALL resolve to CLR (enter/stay IDLE); in RUN SS SHALL win (CLR ignored).
REQ-017 Entering IDLE SHALL zero the live count, prescaler and lap snapshot and deassert LAP_ACTIVE.
REQ-018 Prescaler (26 bits) SHALL increment only in RUN; held unchanged in PAUSE so partial seconds are preserved; zero in IDLE.
REQ-019 When prescaler == DIV-1 in RUN, prescaler SHALL return to 0, TICK SHALL pulse for exactly that cycle (registered, visible next cycle) and the live count SHALL advance by one second.
REQ-020 Live count SHALL be two BCD digits; units 9 -> 0 carries into tens; 59 -> 00 wraps with no other side effect.
REQ-021 LAP event in RUN with LAP_ACTIVE=0 SHALL capture the live count (value after any same-cycle tick) into the snapshot and set LAP_ACTIVE.
REQ-022 LAP event in RUN with LAP_ACTIVE=1 SHALL recapture the snapshot (LAP_ACTIVE stays 1); LAP event in PAUSE or IDLE SHALL clear LAP_ACTIVE.
REQ-023 SEC_ONES/SEC_TENS SHALL be registered: snapshot when LAP_ACTIVE=1, otherwise live count; live count keeps advancing during lap.
REQ-024 RUNNING SHALL be registered and equal (state == RUN).
REQ-025 SS and LAP events in the same cycle SHALL both be applied: lap capture uses the pre-transition state.

Reset
REQ-026 On RST=1 at a CLK edge: state IDLE, prescaler 0, live count 00, snapshot 00, synchronizer and edge registers 0; takes priority over all events.
REQ-027 Output reset values: SEC_ONES=0, SEC_TENS=0, RUNNING=0, LAP_ACTIVE=0, TICK=0; RST mid-RUN or mid-lap SHALL yield the same values on the next cycle.

Verification (DIV=4)
REQ-028 RST, SS press, run 40 cycles -> RUNNING=1 from 4th edge after press; TICK every 4 cycles; display reaches 10 seconds (TENS=1, ONES=0).
REQ-029 Run to 59, one more tick -> display 00, TICK pulses, RUNNING stays 1.
REQ-030 RUN 2 cycles past a tick, SS (PAUSE), wait 20 cycles, SS -> no TICK during PAUSE; next TICK 2 cycles after resume takes effect.
REQ-031 RUN at count 05, LAP -> LAP_ACTIVE=1, display frozen at 05 while 3 ticks occur; SS, then LAP in PAUSE -> display shows 08, LAP_ACTIVE=0.
REQ-032 CLR in RUN -> ignored, count continues; SS+CLR simultaneous in PAUSE -> IDLE, display 00, RUNNING=0.
REQ-033 RST asserted mid-RUN with LAP_ACTIVE=1 -> next cycle all outputs 0; KEY_SS held high through reset release produces no press event.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
// The master drives the keys; the slave (the controller) drives the display.
interface stopwatch_ctrl_if;
    logic       KEY_SS;
    logic       KEY_CLR;
    logic       KEY_LAP;
    logic [3:0] SEC_ONES;
    logic [3:0] SEC_TENS;
    logic       RUNNING;
    logic       LAP_ACTIVE;
    logic       TICK;

    modport master (
        output KEY_SS, KEY_CLR, KEY_LAP,
        input  SEC_ONES, SEC_TENS, RUNNING, LAP_ACTIVE, TICK
    );

    modport slave (
        input  KEY_SS, KEY_CLR, KEY_LAP,
        output SEC_ONES, SEC_TENS, RUNNING, LAP_ACTIVE, TICK
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Seconds stopwatch (00..59) with start/stop, clear and lap-freeze buttons,
// synchronised key inputs and fully registered display outputs.
module stopwatch_ctrl #(
    parameter int unsigned DIV = 50_000_000
) (
    input logic              CLK,
    input logic              RST,
    stopwatch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [25:0] PRESC_MAX = 26'(DIV - 1);

    state_t      state_q, state_d;
    logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [2:0]  armed_q, armed_d;
    logic        sync_valid_q, sync_valid_d;
    logic [25:0] presc_q, presc_d;
    logic [3:0]  ones_q, ones_d, tens_q, tens_d;
    logic [3:0]  snap_ones_q, snap_ones_d, snap_tens_q, snap_tens_d;
    logic        lap_q, lap_d;
    logic [3:0]  out_ones_q, out_ones_d, out_tens_q, out_tens_d;
    logic        running_q, running_d, lap_out_q, lap_out_d, tick_q, tick_d;

    logic [2:0]  press;
    logic        ss_ev, clr_ev, lap_ev, tick_now;

    always_comb begin
        sync1_d      = {bus.KEY_LAP, bus.KEY_CLR, bus.KEY_SS};
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        sync_valid_d = 1'b1;
        // A key only arms once it has been seen released after reset, so a
        // button held through reset release does not produce a press.
        armed_d      = armed_q | ({3{sync_valid_q}} & ~sync1_q);
        press        = sync2_q & ~prev_q & armed_q;
        ss_ev        = press[0];
        clr_ev       = press[1];
        lap_ev       = press[2];
        tick_now     = (state_q == RUN) && (presc_q == PRESC_MAX);

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_ev && !clr_ev) state_d = RUN;
            RUN:     if (ss_ev) state_d = PAUSE;
            PAUSE: begin
                if (clr_ev)     state_d = IDLE;
                else if (ss_ev) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase

        presc_d = presc_q;
        if (state_q == RUN) presc_d = tick_now ? 26'd0 : presc_q + 26'd1;

        ones_d = ones_q;
        tens_d = tens_q;
        if (tick_now) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        // Lap decisions use the state before any same-cycle transition.
        snap_ones_d = snap_ones_q;
        snap_tens_d = snap_tens_q;
        lap_d       = lap_q;
        if (lap_ev) begin
            if (state_q == RUN) begin
                snap_ones_d = ones_d;
                snap_tens_d = tens_d;
                lap_d       = 1'b1;
            end else begin
                lap_d       = 1'b0;
            end
        end

        if (state_d == IDLE) begin
            presc_d     = 26'd0;
            ones_d      = 4'd0;
            tens_d      = 4'd0;
            snap_ones_d = 4'd0;
            snap_tens_d = 4'd0;
            lap_d       = 1'b0;
        end

        out_ones_d = lap_q ? snap_ones_q : ones_q;
        out_tens_d = lap_q ? snap_tens_q : tens_q;
        running_d  = (state_q == RUN);
        lap_out_d  = lap_q;
        tick_d     = tick_now;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            armed_q      <= '0;
            sync_valid_q <= 1'b0;
            presc_q      <= '0;
            ones_q       <= '0;
            tens_q       <= '0;
            snap_ones_q  <= '0;
            snap_tens_q  <= '0;
            lap_q        <= 1'b0;
            out_ones_q   <= '0;
            out_tens_q   <= '0;
            running_q    <= 1'b0;
            lap_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            armed_q      <= armed_d;
            sync_valid_q <= sync_valid_d;
            presc_q      <= presc_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            snap_ones_q  <= snap_ones_d;
            snap_tens_q  <= snap_tens_d;
            lap_q        <= lap_d;
            out_ones_q   <= out_ones_d;
            out_tens_q   <= out_tens_d;
            running_q    <= running_d;
            lap_out_q    <= lap_out_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.SEC_ONES   = out_ones_q;
    assign bus.SEC_TENS   = out_tens_q;
    assign bus.RUNNING    = running_q;
    assign bus.LAP_ACTIVE = lap_out_q;
    assign bus.TICK       = tick_q;
endmodule
